// File: rtl/dma_read_req_arbiter.sv
// Round-robin arbiter that shares one DMA read request channel and tracks per-tag ownership.
// Optional macro DMA_RD_ARB_PRIORITY_EN gives requester 0 strict priority over the rest.
module dma_read_req_arbiter #(
  parameter int p_requesters = 2,
  parameter int IW = $clog2(p_requesters)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [32*p_requesters-1:0] req_addr,
  input  logic [10*p_requesters-1:0] req_len,
  input  logic [p_requesters-1:0]    req_valid,
  output logic [p_requesters-1:0]    req_done,
  output logic [7:0]                 req_tag,
  output logic [31:0]                dma_read_addr,
  output logic [9:0]                 dma_read_len,
  output logic                       dma_read_valid,
  input  logic                       dma_read_done,
  input  logic [7:0]                 current_tag,
  input  logic [7:0]                 packer_tag,
  input  logic                       packer_valid,
  input  logic                       packer_done,
  output logic [IW-1:0]              packer_owner,
  output logic                       packer_owner_valid,
  output logic [8:0]                 outstanding,
  output logic                       all_idle,
  output logic                       tag_collision
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t          state_reg, state_next;
  logic [IW-1:0]   ptr_reg;
  logic [IW-1:0]   grant_reg;
  logic [31:0]     addr_reg;
  logic [9:0]      len_reg;
  logic [7:0]      tag_reg;
  logic [255:0]    busy_reg;
  logic [IW-1:0]   owner_mem [256];
  logic [8:0]      outstanding_reg;
  logic            collision_reg;

  logic            found;
  logic [IW-1:0]   pick;
  logic [IW:0]     idx;
  logic [IW-1:0]   cand;

  logic            tag_set;
  logic            tag_clr;
  logic            clr_same;
  logic            cnt_inc;
  logic            cnt_dec;

  // Search upward from the pointer with wrap; first pending requester wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    cand  = '0;
    for (int i = 0; i < p_requesters; i++) begin
      idx = {1'b0, ptr_reg} + (IW+1)'(i);
      if (idx >= (IW+1)'(p_requesters))
        idx = idx - (IW+1)'(p_requesters);
      cand = idx[IW-1:0];
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
`ifdef DMA_RD_ARB_PRIORITY_EN
    if (req_valid[0]) begin
      found = 1'b1;
      pick  = '0;
    end
`else
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (found) state_next = ISSUE;
      ISSUE:   if (dma_read_done) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_done       = '0;
    dma_read_valid = 1'b0;
    if (state_reg == DONE)  req_done[grant_reg] = 1'b1;
    if (state_reg == ISSUE) dma_read_valid = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_reg   <= '0;
      grant_reg <= '0;
      addr_reg  <= '0;
      len_reg   <= '0;
      tag_reg   <= '0;
    end else begin
      if (state_reg == IDLE && found) begin
        grant_reg <= pick;
        addr_reg  <= req_addr[32*pick +: 32];
        len_reg   <= req_len[10*pick +: 10];
      end
      if (tag_set)
        tag_reg <= current_tag;
      if (state_reg == DONE) begin
`ifdef DMA_RD_ARB_PRIORITY_EN
        if (grant_reg != '0)
          ptr_reg <= (grant_reg == IW'(p_requesters-1)) ? '0 : grant_reg + 1'b1;
`else
        ptr_reg <= (grant_reg == IW'(p_requesters-1)) ? '0 : grant_reg + 1'b1;
`endif
      end
    end
  end

  assign tag_set  = (state_reg == ISSUE) && dma_read_done;
  assign tag_clr  = packer_valid && packer_done && busy_reg[packer_tag];
  assign clr_same = tag_clr && (packer_tag == current_tag);
  // A same-tag set+clear leaves the tag busy, so neither edge of the count moves.
  assign cnt_inc  = tag_set && !busy_reg[current_tag];
  assign cnt_dec  = tag_clr && !(tag_set && clr_same);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_reg        <= '0;
      outstanding_reg <= '0;
      collision_reg   <= 1'b0;
    end else begin
      if (tag_clr)
        busy_reg[packer_tag] <= 1'b0;
      if (tag_set)
        busy_reg[current_tag] <= 1'b1;
      if (tag_set && busy_reg[current_tag] && !clr_same)
        collision_reg <= 1'b1;
      if (cnt_inc && !cnt_dec && outstanding_reg != 9'd256)
        outstanding_reg <= outstanding_reg + 9'd1;
      else if (cnt_dec && !cnt_inc && outstanding_reg != 9'd0)
        outstanding_reg <= outstanding_reg - 9'd1;
    end
  end

  // Owner entries are only meaningful while the busy bit is set, so no reset is needed.
  always_ff @(posedge i_clk) begin
    if (tag_set)
      owner_mem[current_tag] <= grant_reg;
  end

  assign req_tag            = tag_reg;
  assign dma_read_addr      = addr_reg;
  assign dma_read_len       = len_reg;
  assign packer_owner       = owner_mem[packer_tag];
  assign packer_owner_valid = packer_valid && busy_reg[packer_tag];
  assign outstanding        = outstanding_reg;
  assign tag_collision      = collision_reg;
  assign all_idle           = (state_reg == IDLE) && (outstanding_reg == 9'd0) && !(|req_valid);

endmodule

// File: tb/tb_dma_read_req_arbiter.sv
// Directed bench for dma_read_req_arbiter (N=2), checked with immediate assertions.
module tb_dma_read_req_arbiter;

  localparam int N  = 2;
  localparam int IW = 1;

  logic            i_clk = 1'b0;
  logic            i_rst_n = 1'b0;
  logic [32*N-1:0] req_addr = '0;
  logic [10*N-1:0] req_len = '0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_done;
  logic [7:0]      req_tag;
  logic [31:0]     dma_read_addr;
  logic [9:0]      dma_read_len;
  logic            dma_read_valid;
  logic            dma_read_done = 1'b0;
  logic [7:0]      current_tag = '0;
  logic [7:0]      packer_tag = '0;
  logic            packer_valid = 1'b0;
  logic            packer_done = 1'b0;
  logic [IW-1:0]   packer_owner;
  logic            packer_owner_valid;
  logic [8:0]      outstanding;
  logic            all_idle;
  logic            tag_collision;

  int n_assert = 0;
  int n_fail   = 0;
  logic [N-1:0] rd;
  logic [N-1:0] exp_rr [4];

  dma_read_req_arbiter #(.p_requesters(N)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .req_addr(req_addr), .req_len(req_len), .req_valid(req_valid),
    .req_done(req_done), .req_tag(req_tag),
    .dma_read_addr(dma_read_addr), .dma_read_len(dma_read_len),
    .dma_read_valid(dma_read_valid), .dma_read_done(dma_read_done),
    .current_tag(current_tag),
    .packer_tag(packer_tag), .packer_valid(packer_valid), .packer_done(packer_done),
    .packer_owner(packer_owner), .packer_owner_valid(packer_owner_valid),
    .outstanding(outstanding), .all_idle(all_idle), .tag_collision(tag_collision)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the request, accept it with the given tag, return req_done in DONE.
  task automatic grant(input logic [7:0] tag, output logic [N-1:0] done_seen);
    int n;
    n = 0;
    while (!dma_read_valid && n < 8) begin
      tick();
      n++;
    end
    chk("grant_valid", 32'(dma_read_valid), 32'd1);
    dma_read_done = 1'b1;
    current_tag   = tag;
    tick();
    dma_read_done = 1'b0;
    done_seen     = req_done;
    $display("grant tag=0x%02h req_done=%b req_tag=0x%02h outstanding=%0d", tag, req_done, req_tag, outstanding);
  endtask

  initial begin
`ifdef DMA_RD_ARB_PRIORITY_EN
    exp_rr[0] = 2'b01; exp_rr[1] = 2'b01; exp_rr[2] = 2'b01; exp_rr[3] = 2'b01;
`else
    exp_rr[0] = 2'b01; exp_rr[1] = 2'b10; exp_rr[2] = 2'b01; exp_rr[3] = 2'b10;
`endif
    #23;
    chk("rst_valid", 32'(dma_read_valid), 32'd0);
    chk("rst_addr", dma_read_addr, 32'd0);
    chk("rst_req_done", 32'(req_done), 32'd0);
    chk("rst_req_tag", 32'(req_tag), 32'd0);
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    chk("rst_all_idle", 32'(all_idle), 32'd1);
    chk("rst_collision", 32'(tag_collision), 32'd0);
    i_rst_n = 1'b1;
    tick();

    // Single request from requester 1
    req_addr[63:32] = 32'h1000_0040;
    req_len[19:10]  = 10'd16;
    req_addr[31:0]  = 32'hAAAA_0000;
    req_len[9:0]    = 10'd4;
    req_valid = 2'b10;
    #1;
    chk("single_not_yet", 32'(dma_read_valid), 32'd0);
    chk("single_not_idle", 32'(all_idle), 32'd0);
    tick();
    chk("single_valid", 32'(dma_read_valid), 32'd1);
    chk("single_addr", dma_read_addr, 32'h1000_0040);
    chk("single_len", 32'(dma_read_len), 32'd16);
    req_addr[63:32] = 32'hDEAD_BEEF;
    tick();
    tick();
    chk("single_hold_addr", dma_read_addr, 32'h1000_0040);
    chk("single_hold_valid", 32'(dma_read_valid), 32'd1);
    grant(8'h05, rd);
    chk("single_req_done", 32'(rd), 32'b10);
    chk("single_req_tag", 32'(req_tag), 32'h05);
    chk("single_outstanding", 32'(outstanding), 32'd1);
    chk("single_valid_drop", 32'(dma_read_valid), 32'd0);
    req_valid = 2'b00;
    tick();
    chk("single_done_pulse", 32'(req_done), 32'd0);

    // Fairness with both requesters held
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      grant(8'(8'h20 + i), rd);
      chk("rr_order", 32'(rd), 32'(exp_rr[i]));
      tick();
    end
    req_valid = 2'b00;
    chk("rr_outstanding", 32'(outstanding), 32'd5);

    // Completion routing: tag 0x06 to requester 0
    req_valid = 2'b01;
    grant(8'h06, rd);
    chk("route_req_done", 32'(rd), 32'b01);
    req_valid = 2'b00;
    tick();
    chk("route_outstanding", 32'(outstanding), 32'd6);
    packer_valid = 1'b1;
    packer_tag   = 8'h06;
    #1;
    chk("route_owner6", 32'(packer_owner), 32'd0);
    chk("route_ov6", 32'(packer_owner_valid), 32'd1);
    packer_tag  = 8'h05;
    packer_done = 1'b1;
    #1;
    chk("route_owner5", 32'(packer_owner), 32'd1);
    chk("route_ov5", 32'(packer_owner_valid), 32'd1);
    tick();
    packer_done = 1'b0;
    chk("route_out_drop", 32'(outstanding), 32'd5);
    chk("route_ov5_clear", 32'(packer_owner_valid), 32'd0);
    packer_tag  = 8'h33;
    packer_done = 1'b1;
    tick();
    packer_done  = 1'b0;
    packer_valid = 1'b0;
    chk("clr_nonbusy", 32'(outstanding), 32'd5);

    // Simultaneous set and clear on tag 0x07
    req_valid = 2'b10;
    grant(8'h07, rd);
    req_valid = 2'b00;
    tick();
    chk("sim_pre_out", 32'(outstanding), 32'd6);
    req_valid = 2'b01;
    tick();
    packer_valid = 1'b1;
    packer_done  = 1'b1;
    packer_tag   = 8'h07;
    grant(8'h07, rd);
    packer_done = 1'b0;
    req_valid   = 2'b00;
    #1;
    chk("sim_out", 32'(outstanding), 32'd6);
    chk("sim_busy", 32'(packer_owner_valid), 32'd1);
    chk("sim_owner", 32'(packer_owner), 32'd0);
    chk("sim_collision", 32'(tag_collision), 32'd0);
    packer_valid = 1'b0;
    tick();

    // Collision on tag 0x09
    req_valid = 2'b01;
    grant(8'h09, rd);
    req_valid = 2'b00;
    tick();
    chk("col_first", 32'(tag_collision), 32'd0);
    req_valid = 2'b10;
    grant(8'h09, rd);
    req_valid = 2'b00;
    tick();
    chk("col_set", 32'(tag_collision), 32'd1);
    chk("col_out", 32'(outstanding), 32'd7);
    tick();
    chk("col_sticky", 32'(tag_collision), 32'd1);

    // Reset while a request is in ISSUE
    req_valid = 2'b01;
    tick();
    chk("rstmid_valid", 32'(dma_read_valid), 32'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("rstmid_valid_async", 32'(dma_read_valid), 32'd0);
    chk("rstmid_out", 32'(outstanding), 32'd0);
    chk("rstmid_collision", 32'(tag_collision), 32'd0);
    req_valid = 2'b00;
    tick();
    i_rst_n = 1'b1;
    tick();
    chk("rstmid_all_idle", 32'(all_idle), 32'd1);
    chk("rstmid_req_tag", 32'(req_tag), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
